// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared constants, decoder states and BCD helper for the PS/2 key path
package ps2_pkg;

    localparam logic [7:0] PS2_BREAK = 8'hF0;
    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam int         FRAME_LEN = 11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DOWN = 2'd1,
        BRK  = 2'd2
    } state_t;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v[3:0] == 4'd9) begin
            if (v[7:4] == 4'd9) return 8'h00;
            return {v[7:4] + 4'd1, 4'd0};
        end
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

endpackage

// File: rtl/ps2_rx.sv
// rtl/ps2_rx.sv - PS/2 pin synchronizer, 11-bit frame deserializer, timeout and frame check
module ps2_rx #(
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       byte_vld,
    output logic       err
);
    import ps2_pkg::*;

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [2:0]    clk_sync;
    logic [2:0]    data_sync;
    logic          clk_prev;
    logic [3:0]    bit_cnt;
    logic [9:0]    shreg;
    logic [TW-1:0] tmo;
    logic          fall;
    logic [10:0]   frame;
    logic          frame_ok;

    // Synchronizers run through reset so no false edge appears when clrn releases.
    always_ff @(posedge clk) begin
        clk_sync  <= {clk_sync[1:0], ps2_clk};
        data_sync <= {data_sync[1:0], ps2_data};
        clk_prev  <= clk_sync[2];
    end

    assign fall     = clk_prev & ~clk_sync[2];
    assign frame    = {data_sync[2], shreg};
    assign frame_ok = ~frame[0] & frame[10] & (^frame[9:1]);

    always_ff @(posedge clk) begin
        if (!clrn) begin
            bit_cnt  <= 4'd0;
            shreg    <= 10'd0;
            tmo      <= '0;
            rx_byte  <= 8'h00;
            byte_vld <= 1'b0;
            err      <= 1'b0;
        end else begin
            byte_vld <= 1'b0;
            err      <= 1'b0;
            if (fall) begin
                tmo   <= '0;
                shreg <= frame[10:1];
                if (bit_cnt == 4'(FRAME_LEN - 1)) begin
                    bit_cnt <= 4'd0;
                    if (frame_ok) begin
                        rx_byte  <= frame[8:1];
                        byte_vld <= 1'b1;
                    end else begin
                        err <= 1'b1;
                    end
                end else begin
                    bit_cnt <= bit_cnt + 4'd1;
                end
            end else if (bit_cnt != 4'd0) begin
                if (tmo == TW'(TIMEOUT_CYC - 1)) begin
                    bit_cnt <= 4'd0;
                    tmo     <= '0;
                end else begin
                    tmo <= tmo + TW'(1);
                end
            end else begin
                tmo <= '0;
            end
        end
    end

endmodule

// File: rtl/ps2_key_scan.sv
// rtl/ps2_key_scan.sv - make/break decoder, held scan code and BCD press counter
module ps2_key_scan #(
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [3:0] code_hi,
    output logic [3:0] code_lo,
    output logic [3:0] cnt_hi,
    output logic [3:0] cnt_lo,
    output logic       key_down,
    output logic       byte_vld,
    output logic       frame_err
);
    import ps2_pkg::*;

    logic [7:0] rx_byte;
    logic       rx_vld;
    logic       rx_err;
    state_t     state, state_nxt;
    logic       brk_dn, brk_dn_nxt;
    logic [7:0] code, code_nxt;
    logic [7:0] cnt;
    logic       inc;

    ps2_rx #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_rx (
        .clk      (clk),
        .clrn     (clrn),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .rx_byte  (rx_byte),
        .byte_vld (rx_vld),
        .err      (rx_err)
    );

    always_comb begin
        state_nxt  = state;
        brk_dn_nxt = brk_dn;
        code_nxt   = code;
        inc        = 1'b0;
        if (rx_vld && rx_byte != PS2_EXT) begin
            case (state)
                IDLE: begin
                    if (rx_byte == PS2_BREAK) begin
                        state_nxt  = BRK;
                        brk_dn_nxt = 1'b0;
                    end else begin
                        state_nxt = DOWN;
                        code_nxt  = rx_byte;
                        inc       = 1'b1;
                    end
                end
                DOWN: begin
                    if (rx_byte == PS2_BREAK) begin
                        state_nxt  = BRK;
                        brk_dn_nxt = 1'b1;
                    end else if (rx_byte != code) begin
                        code_nxt = rx_byte;
                        inc      = 1'b1;
                    end
                end
                BRK: begin
                    // Releasing some other key leaves the held key down.
                    state_nxt = (brk_dn && rx_byte != code) ? DOWN : IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!clrn) begin
            state     <= IDLE;
            brk_dn    <= 1'b0;
            code      <= 8'h00;
            cnt       <= 8'h00;
            key_down  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            brk_dn    <= brk_dn_nxt;
            code      <= code_nxt;
            if (inc) cnt <= bcd_inc(cnt);
            key_down  <= (state_nxt == DOWN) || (state_nxt == BRK && brk_dn_nxt);
            frame_err <= frame_err | rx_err;
        end
    end

    assign code_hi  = code[7:4];
    assign code_lo  = code[3:0];
    assign cnt_hi   = cnt[7:4];
    assign cnt_lo   = cnt[3:0];
    assign byte_vld = rx_vld;

endmodule

// File: tb/tb_ps2_key_scan.sv
// tb/tb_ps2_key_scan.sv - scoreboard bench for ps2_key_scan
module tb_ps2_key_scan;

    localparam int TMO  = 100;
    localparam int HALF = 8;

    logic       clk = 1'b0;
    logic       clrn = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [3:0] code_hi, code_lo, cnt_hi, cnt_lo;
    logic       key_down, byte_vld, frame_err;

    typedef struct {
        logic [7:0] code;
        logic [7:0] cnt;
        logic       kd;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;
    int   pulses = 0;

    always #5 clk = ~clk;

    ps2_key_scan #(.TIMEOUT_CYC(TMO)) dut (
        .clk       (clk),
        .clrn      (clrn),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .code_hi   (code_hi),
        .code_lo   (code_lo),
        .cnt_hi    (cnt_hi),
        .cnt_lo    (cnt_lo),
        .key_down  (key_down),
        .byte_vld  (byte_vld),
        .frame_err (frame_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic expect_out(input logic [7:0] c, input logic [7:0] n, input logic kd);
        exp_t e;
        e.code = c;
        e.cnt  = n;
        e.kd   = kd;
        q.push_back(e);
    endtask

    // Monitor: outputs settle one clock after each byte_vld pulse.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (byte_vld) begin
                pulses++;
                @(negedge clk);
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_byte actual_code=%0h expected=none", {code_hi, code_lo});
                end else begin
                    e = q.pop_front();
                    chk("code", {code_hi, code_lo}, e.code);
                    chk("cnt", {cnt_hi, cnt_lo}, e.cnt);
                    chk("key_down", key_down, e.kd);
                end
            end
        end
    end

    task automatic send_bits(input logic [10:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_data = f[i];
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b1;
        end
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] b, input logic bad);
        return {1'b1, (~^b) ^ bad, b, 1'b0};
    endfunction

    task automatic send_byte(input logic [7:0] b, input logic bad);
        send_bits(mk_frame(b, bad), 11);
        ps2_data = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(name, q.size(), 0);
    endtask

    task automatic do_reset();
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        clrn     = 1'b0;
        repeat (3) @(negedge clk);
        clrn = 1'b1;
        @(negedge clk);
        chk("rst_code", {code_hi, code_lo}, 8'h00);
        chk("rst_cnt", {cnt_hi, cnt_lo}, 8'h00);
        chk("rst_key_down", key_down, 1'b0);
        chk("rst_frame_err", frame_err, 1'b0);
    endtask

    initial begin
        int p0;
        logic [7:0] b;
        logic [7:0] n_bcd;

        do_reset();

        expect_out(8'h1C, 8'h01, 1'b1); send_byte(8'h1C, 1'b0);
        expect_out(8'h1C, 8'h01, 1'b1); send_byte(8'hF0, 1'b0);
        expect_out(8'h1C, 8'h01, 1'b0); send_byte(8'h1C, 1'b0);
        drain("press_release_drain");

        do_reset();
        p0 = pulses;
        for (int i = 0; i < 5; i++) begin
            expect_out(8'h1C, 8'h01, 1'b1); send_byte(8'h1C, 1'b0);
        end
        expect_out(8'h1C, 8'h01, 1'b1); send_byte(8'hF0, 1'b0);
        expect_out(8'h1C, 8'h01, 1'b0); send_byte(8'h1C, 1'b0);
        drain("typematic_drain");
        chk("typematic_pulses", pulses - p0, 7);

        do_reset();
        expect_out(8'h00, 8'h00, 1'b0); send_byte(8'hE0, 1'b0);
        expect_out(8'h75, 8'h01, 1'b1); send_byte(8'h75, 1'b0);
        expect_out(8'h2A, 8'h02, 1'b1); send_byte(8'h2A, 1'b0);
        drain("extended_drain");

        p0 = pulses;
        send_byte(8'h1C, 1'b1);
        chk("badpar_pulses", pulses - p0, 0);
        chk("badpar_frame_err", frame_err, 1'b1);
        chk("badpar_code", {code_hi, code_lo}, 8'h2A);
        chk("badpar_cnt", {cnt_hi, cnt_lo}, 8'h02);

        do_reset();
        send_bits(mk_frame(8'h55, 1'b0), 4);
        ps2_data = 1'b1;
        repeat (TMO + 10) @(negedge clk);
        expect_out(8'h1C, 8'h01, 1'b1); send_byte(8'h1C, 1'b0);
        drain("timeout_drain");
        chk("timeout_frame_err", frame_err, 1'b0);

        send_bits(mk_frame(8'h33, 1'b0), 5);
        do_reset();
        expect_out(8'h1C, 8'h01, 1'b1); send_byte(8'h1C, 1'b0);
        drain("midreset_drain");
        chk("midreset_frame_err", frame_err, 1'b0);

        do_reset();
        for (int i = 1; i <= 100; i++) begin
            b = (i % 2 == 1) ? 8'h1B : 8'h1C;
            n_bcd = (i == 100) ? 8'h00 : 8'((((i / 10) % 10) << 4) | (i % 10));
            expect_out(b, n_bcd, 1'b1);
            send_byte(b, 1'b0);
        end
        drain("wrap_drain");
        chk("wrap_cnt", {cnt_hi, cnt_lo}, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
